// File: rtl/p2c_lane_fb.sv
// Multi-lane p2c feedback cell: per-lane state bit k picks between ~(a|b) and b^c,
// with mode-selectable feedback, optional output register and a saturating toggle counter.
module p2c_lane_fb #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] f,
  output logic             f_vld,
  output logic [WIDTH-1:0] k_q,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             tog_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] fc;
  logic [WIDTH-1:0] j;
  logic             toggle;

  assign h  = ~(a | b);
  assign g  = b ^ c;
  assign n  = ~(c & d);
  assign fc = (k & g) | (~k & h);

  always_comb begin
    j = k;
    case (mode)
      2'b00:   j = n | fc;
      2'b01:   j = n & fc;
      2'b10:   j = ~k;
      default: j = k;
    endcase
  end

  assign toggle = en && (j != k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (en) begin
      k <= j;
    end
  end

  // Clear beats a simultaneous toggle event; the counter parks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_cnt <= '0;
      tog_sat <= 1'b0;
    end else if (cnt_clr) begin
      tog_cnt <= '0;
      tog_sat <= 1'b0;
    end else if (toggle && (tog_cnt != CNT_MAX)) begin
      tog_cnt <= tog_cnt + 1'b1;
      if (tog_cnt == CNT_MAX - 1'b1) begin
        tog_sat <= 1'b1;
      end
    end
  end

  assign k_q = k;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] f_r;
      logic             vld_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          f_r   <= '0;
          vld_r <= 1'b0;
        end else begin
          f_r   <= fc;
          vld_r <= 1'b1;
        end
      end
      assign f     = f_r;
      assign f_vld = vld_r;
    end else begin : g_out_comb
      assign f     = fc;
      assign f_vld = ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_p2c_lane_fb.sv
// Self-checking bench: a combinational-output instance and a registered-output,
// 3-bit-counter instance share stimulus and are compared against a per-lane model.
module tb_p2c_lane_fb;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a, b, c, d;
  logic       cnt_clr;

  logic [3:0] fA, kA, fB, kB;
  logic       vA, vB, sA, sB;
  logic [7:0] cA;
  logic [2:0] cB;

  int ncmp = 0;
  int nerr = 0;

  logic [3:0] mk;
  int         mcA, mcB;
  bit         msA, msB;
  logic [3:0] mfB;
  bit         mvB;

  always #5 clk = ~clk;

  p2c_lane_fb #(.WIDTH(4), .CNT_W(8), .OUT_REG(0)) dutA (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .cnt_clr(cnt_clr), .f(fA), .f_vld(vA), .k_q(kA), .tog_cnt(cA), .tog_sat(sA)
  );

  p2c_lane_fb #(.WIDTH(4), .CNT_W(3), .OUT_REG(1)) dutB (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .cnt_clr(cnt_clr), .f(fB), .f_vld(vB), .k_q(kB), .tog_cnt(cB), .tog_sat(sB)
  );

  function automatic logic [3:0] laneF(input logic [3:0] kk);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = kk[i] ? (b[i] != c[i]) : !(a[i] || b[i]);
    end
    return r;
  endfunction

  function automatic logic [3:0] nextK(input logic [3:0] kk);
    logic [3:0] r;
    logic [3:0] fv;
    bit         nn;
    fv = laneF(kk);
    for (int i = 0; i < 4; i++) begin
      nn = !(c[i] && d[i]);
      case (int'(mode))
        0:       r[i] = nn || fv[i];
        1:       r[i] = nn && fv[i];
        2:       r[i] = !kk[i];
        default: r[i] = kk[i];
      endcase
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string ctx);
    cmp({ctx, " kA"}, 32'(kA), 32'(mk));
    cmp({ctx, " kB"}, 32'(kB), 32'(mk));
    cmp({ctx, " fA"}, 32'(fA), rst ? 32'(laneF(4'h0)) : 32'(laneF(mk)));
    cmp({ctx, " fB"}, 32'(fB), 32'(mfB));
    cmp({ctx, " vldA"}, 32'(vA), rst ? 32'd0 : 32'd1);
    cmp({ctx, " vldB"}, 32'(vB), 32'(mvB));
    cmp({ctx, " cntA"}, 32'(cA), 32'(mcA));
    cmp({ctx, " cntB"}, 32'(cB), 32'(mcB));
    cmp({ctx, " satA"}, 32'(sA), 32'(msA));
    cmp({ctx, " satB"}, 32'(sB), 32'(msB));
  endtask

  task automatic modelReset();
    mk = 4'h0; mcA = 0; mcB = 0; msA = 0; msB = 0; mfB = 4'h0; mvB = 0;
  endtask

  // One rising edge: the model's next state is taken from the pre-edge inputs.
  task automatic applyStimulus(input string ctx);
    logic [3:0] nk;
    logic [3:0] fcNow;
    bit         ev;
    nk    = nextK(mk);
    fcNow = laneF(mk);
    ev    = en && (nk != mk);
    @(posedge clk);
    #1;
    if (cnt_clr) begin
      mcA = 0; msA = 0; mcB = 0; msB = 0;
    end else if (ev) begin
      if (mcA < 255) mcA++;
      if (mcA == 255) msA = 1;
      if (mcB < 7) mcB++;
      if (mcB == 7) msB = 1;
    end
    if (en) mk = nk;
    mfB = fcNow;
    mvB = 1;
    checkOutput(ctx);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; cnt_clr = 1'b0;
    a = 4'h0; b = 4'h0; c = 4'hF; d = 4'hF;
    modelReset();
    #12;
    checkOutput("reset");
    rst = 1'b0;
    #1;
    checkOutput("post-deassert");

    applyStimulus("legacy1");
    for (int i = 0; i < 3; i++) applyStimulus("legacy-hold");

    mode = 2'b11;
    for (int i = 0; i < 5; i++) applyStimulus("mode-hold");
    mode = 2'b10; en = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus("en-low");

    en = 1'b1; mode = 2'b11; cnt_clr = 1'b1;
    applyStimulus("clr");
    cnt_clr = 1'b0; mode = 2'b10;
    for (int i = 0; i < 10; i++) applyStimulus("toggle-sat");
    cnt_clr = 1'b1; mode = 2'b11;
    applyStimulus("clr-after-sat");
    mode = 2'b10;
    applyStimulus("clr-vs-toggle");
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus("toggle-more");

    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      mode    = 2'($urandom);
      a       = 4'($urandom);
      b       = 4'($urandom);
      c       = 4'($urandom);
      d       = 4'($urandom);
      cnt_clr = ($urandom_range(0, 63) == 0);
      applyStimulus("random");
    end

    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async-reset");
    #1;
    rst = 1'b0; en = 1'b1; mode = 2'b11; cnt_clr = 1'b0;
    a = 4'h3; b = 4'h0; c = 4'h0; d = 4'h0;
    #1;
    cmp("fA-C", 32'(fA), 32'hC);
    applyStimulus("outreg");
    cmp("fB-C", 32'(fB), 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
